int_arbiter: RTL and testbench
==============================

Name: int_arbiter

Overview:
Multi-source interrupt controller that sits ahead of the PC/EPC unit in the single-cycle CPU. It latches edge-triggered requests from NUM_SRC peripherals, applies per-source masks and a global enable, and picks one winner. It drives the one-cycle INT strobe into the PC unit and blocks further interrupts until the handler executes eret (no nesting). Software configures and inspects it through a small register port.

Parameters:
NUM_SRC, 4, number of interrupt sources (2..16)
IDW, 2, width of cause index; must satisfy 2**IDW >= NUM_SRC

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
irq  in  NUM_SRC  raw request lines, one per source, synchronous to clk
eret  in  1  return-from-exception decode, same signal fed to the PC unit
cfg_we  in  1  config register write strobe
cfg_addr  in  2  config register select
cfg_wdata  in  32  config write data
cfg_rdata  out  32  config read data, combinational from cfg_addr
int_out  out  1  interrupt strobe, drives PC unit INT input
cause  out  IDW  index of the source being serviced
in_service  out  1  high while a handler is active

Behaviour:
- Reset (async): irq_q=0, pending=0, mask=0, gie=0, state=IDLE, cause=0, int_out=0, in_service=0.
- Edge detect: rise = irq & ~irq_q; irq_q <= irq every edge. A line held high across reset registers as an edge on the first post-reset clock.
- Pending: pending[i] is set on rise[i] and cleared on grant or on a W1C write. If set and clear hit the same cycle, set wins.
- Eligible vector: elig = pending & mask, gated by gie.
- State IDLE:
  - in_service=0.
  - int_out=1, combinational, whenever |elig.
  - At that clock edge: state->SERVICE, cause<=winner, pending[winner] cleared.
  - The PC unit redirects on the same edge.
  - eret in IDLE is ignored by this block.
- State SERVICE:
  - int_out=0, in_service=1; new edges accumulate in pending.
  - eret=1 -> IDLE at the next edge. int_out can assert no earlier than the cycle after, which guarantees EPC is restored before re-entry.
- Arbitration: fixed priority, lowest index wins.
- Latency: irq rises during cycle k -> pending set at edge k -> int_out high in cycle k+1 (when eligible and IDLE) -> handler PC at edge k+1.
- Masked or gie=0 requests stay pending. They fire once enabled, in the first IDLE cycle after the enabling write.
- Config map, writes take effect at the clock edge:
  - addr0 MASK: bits[NUM_SRC-1:0] R/W.
  - addr1 STATUS: bit0 gie R/W.
  - addr2 PENDING: read pending; write 1 to clear.
  - addr3 CAUSE: read-only, {in_service at bit31, cause at [IDW-1:0]}; writes ignored.
  - Unused bits read 0.
- A write that enables a source in the same cycle it becomes pending takes effect next cycle; int_out uses pre-write mask/gie.
- Reset mid-SERVICE returns to IDLE with all state cleared; in-flight requests are lost.

Optional Feature:
INT_RR_EN:
- Defined: round-robin arbitration.
  - Pointer rr_ptr (IDW bits) resets to 0.
  - Search starts at rr_ptr and wraps modulo NUM_SRC.
  - On grant, rr_ptr <= (winner+1) mod NUM_SRC.
- Undefined: fixed priority as above; no pointer register exists.

Test Plan:
- Reset, then MASK=0xF, gie=1, pulse irq[2] at cycle 5 -> int_out high exactly cycle 6, cause=2, in_service=1 from edge 6, pending=0.
- irq[1] and irq[3] rise the same cycle -> first grant cause=1, pending=0x8. After eret, one idle cycle, then int_out with cause=3. With INT_RR_EN, a second simultaneous pair 1,3 after grant 3 -> cause=1 still wins, since the pointer wrapped to 0.
- gie=0, irq[0] pulse -> no int_out, PENDING reads 0x1. Write gie=1 -> int_out the next cycle, cause=0.
- In SERVICE, irq[2] pulses while eret=1 the same cycle -> state IDLE next edge, int_out asserted the following cycle, cause=2.
- irq[1] edge the same cycle as W1C write 0x2 to PENDING -> PENDING reads 0x2 afterwards (set wins).
- Assert reset asynchronously mid-SERVICE -> int_out, in_service, cause, pending, mask, and gie are all 0 immediately; cfg_rdata at addr3 reads 0.

Source files
------------

// File: rtl/int_arbiter_if.sv
// rtl/int_arbiter_if.sv - request/return, config and interrupt signal bundle for int_arbiter
//
// Signals:
//   irq        raw request lines, one per source, synchronous to clk
//   eret       return-from-exception decode, same signal fed to the PC unit
//   cfg_we     config register write strobe
//   cfg_addr   config register select
//   cfg_wdata  config write data
//   cfg_rdata  config read data, combinational from cfg_addr
//   int_out    one-cycle interrupt strobe into the PC unit INT input
//   cause      index of the source being serviced
//   in_service high while a handler is active
// Modports: master = CPU/peripheral side, slave = int_arbiter.
interface int_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = 2
);
    logic [NUM_SRC-1:0] irq;
    logic               eret;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               int_out;
    logic [IDW-1:0]     cause;
    logic               in_service;

    modport master (
        output irq, eret, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, int_out, cause, in_service
    );

    modport slave (
        input  irq, eret, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, int_out, cause, in_service
    );
endinterface

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - edge-latched multi-source interrupt arbiter ahead of the PC/EPC unit
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    int_arbiter_if.slave (irq, eret, cfg_we/addr/wdata/rdata, int_out, cause, in_service)
// Config map: 0 MASK (R/W), 1 STATUS bit0 gie (R/W), 2 PENDING (R, W1C),
//             3 CAUSE (RO: bit31 in_service, [IDW-1:0] cause).
// Build option: define INT_RR_EN for round-robin arbitration; default is
//               fixed priority, lowest index wins.
module int_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = 2
) (
    input  logic         clk,
    input  logic         reset,
    int_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] SERVICE = 1'b1;

    logic [0:0]         state;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               gie;
    logic [IDW-1:0]     cause_q;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] grant_vec;
    logic [NUM_SRC-1:0] w1c_vec;
    logic [IDW-1:0]     winner;
    logic               grant;

    wire unused_wdata = &{1'b0, bus.cfg_wdata};

    assign rise  = bus.irq & ~irq_q;
    assign elig  = gie ? (pending & mask) : '0;
    assign grant = (state == IDLE) && (|elig);

`ifdef INT_RR_EN
    logic [IDW-1:0] rr_ptr;

    // Walk the offsets from the far end toward rr_ptr so the last hit
    // (the one nearest rr_ptr in wrap order) is the one that sticks.
    always_comb begin
        winner = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            logic [IDW:0] idx;
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_SRC))
                idx = idx - (IDW+1)'(NUM_SRC);
            if (elig[idx[IDW-1:0]])
                winner = idx[IDW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= (winner == IDW'(NUM_SRC - 1)) ? '0 : winner + IDW'(1);
    end
`else
    // Descending scan: the lowest eligible index is assigned last and wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i])
                winner = IDW'(i);
        end
    end
`endif

    assign grant_vec = grant ? (NUM_SRC'(1) << winner) : '0;
    assign w1c_vec   = (bus.cfg_we && bus.cfg_addr == 2'd2) ? bus.cfg_wdata[NUM_SRC-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
            gie     <= 1'b0;
            state   <= IDLE;
            cause_q <= '0;
        end else begin
            irq_q <= bus.irq;
            // A fresh edge beats a same-cycle grant or W1C clear.
            pending <= (pending & ~(grant_vec | w1c_vec)) | rise;
            if (bus.cfg_we && bus.cfg_addr == 2'd0)
                mask <= bus.cfg_wdata[NUM_SRC-1:0];
            if (bus.cfg_we && bus.cfg_addr == 2'd1)
                gie <= bus.cfg_wdata[0];
            case (state)
                IDLE: begin
                    if (grant) begin
                        state   <= SERVICE;
                        cause_q <= winner;
                    end
                end
                default: begin
                    if (bus.eret)
                        state <= IDLE;
                end
            endcase
        end
    end

    assign bus.int_out    = grant;
    assign bus.cause      = cause_q;
    assign bus.in_service = (state == SERVICE);

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = 32'(mask);
            2'd1:    bus.cfg_rdata = {31'b0, gie};
            2'd2:    bus.cfg_rdata = 32'(pending);
            default: bus.cfg_rdata = {(state == SERVICE), {(31-IDW){1'b0}}, cause_q};
        endcase
    end
endmodule

// File: tb/tb_int_arbiter.sv
// tb/tb_int_arbiter.sv - scoreboard bench for int_arbiter with a behavioural reference model
module tb_int_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk;
    logic reset;

    int_arbiter_if #(.NUM_SRC(N), .IDW(IDW)) bus ();

    int_arbiter #(.NUM_SRC(N), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           io;
        logic [IDW-1:0] c;
        logic           sv;
        logic [31:0]    rd;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state, one entry per source.
    bit           m_prev [N];
    bit           m_pend [N];
    bit           m_mask [N];
    bit           m_gie;
    bit           m_svc;
    int           m_cause;
    int           m_rr;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
        end
        m_gie = 0; m_svc = 0; m_cause = 0; m_rr = 0;
    endtask

    function automatic logic [31:0] pack(bit v [N]);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < N; i++) r = r + (v[i] ? (32'd1 << i) : 32'd0);
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push the model's expectation, advance the model.
    task automatic step(input logic [N-1:0] irq, input logic eret, input logic we,
                        input logic [1:0] addr, input logic [31:0] wd);
        exp_t e;
        bit   any;
        int   win;
        bit   nxt [N];
        bus.irq = irq; bus.eret = eret; bus.cfg_we = we;
        bus.cfg_addr = addr; bus.cfg_wdata = wd;

        any = 0; win = 0;
        for (int k = 0; k < N; k++) begin
            int i;
`ifdef INT_RR_EN
            i = (m_rr + k) % N;
`else
            i = k;
`endif
            if (!any && m_gie && m_pend[i] && m_mask[i]) begin
                any = 1; win = i;
            end
        end

        e.io = !m_svc && any;
        e.c  = m_cause[IDW-1:0];
        e.sv = m_svc;
        case (addr)
            2'd0:    e.rd = pack(m_mask);
            2'd1:    e.rd = m_gie ? 32'd1 : 32'd0;
            2'd2:    e.rd = pack(m_pend);
            default: e.rd = (m_svc ? 32'h8000_0000 : 32'd0) + 32'(m_cause);
        endcase
        sbq.push_back(e);

        for (int i = 0; i < N; i++) begin
            bit granted, cleared, edge_seen;
            granted   = e.io && (i == win);
            cleared   = we && addr == 2'd2 && wd[i];
            edge_seen = irq[i] && !m_prev[i];
            nxt[i]    = edge_seen || (m_pend[i] && !granted && !cleared);
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = nxt[i];
            m_prev[i] = irq[i];
            if (we && addr == 2'd0) m_mask[i] = wd[i];
        end
        if (we && addr == 2'd1) m_gie = wd[0];
        if (e.io) begin
            m_svc   = 1;
            m_cause = win;
            m_rr    = (win + 1) % N;
        end else if (m_svc && eret) begin
            m_svc = 0;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, 2'd3, 32'd0);
    endtask

    // Asynchronous reset between edges; everything must clear at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_int_out", 32'(bus.int_out), 32'd0);
        chk("rst_in_service", 32'(bus.in_service), 32'd0);
        chk("rst_cause", 32'(bus.cause), 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.cfg_addr = a[1:0];
            #1;
            chk($sformatf("rst_rdata%0d", a), bus.cfg_rdata, 32'd0);
        end
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            if (bus.int_out !== e.io || bus.cause !== e.c ||
                bus.in_service !== e.sv || bus.cfg_rdata !== e.rd) begin
                miscompares++;
                $display("FAIL vec%0d: got int_out=%b cause=%0d in_service=%b rdata=%h expected int_out=%b cause=%0d in_service=%b rdata=%h",
                         vectors, bus.int_out, bus.cause, bus.in_service, bus.cfg_rdata,
                         e.io, e.c, e.sv, e.rd);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.irq = '0; bus.eret = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'd0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Single source: edge at cycle 5, strobe cycle 6.
        step('0, 0, 1, 2'd0, 32'hF);
        step('0, 0, 1, 2'd1, 32'h1);
        idle(2);
        step(4'b0100, 0, 0, 2'd2, 0);
        chk("t1_int_out", 32'(bus.int_out), 32'd1);
        step('0, 0, 0, 2'd2, 0);
        chk("t1_int_low", 32'(bus.int_out), 32'd0);
        chk("t1_cause", 32'(bus.cause), 32'd2);
        chk("t1_in_service", 32'(bus.in_service), 32'd1);
        chk("t1_pending", bus.cfg_rdata, 32'd0);
        step('0, 1, 0, 2'd3, 0);
        idle(1);

        // Simultaneous 1 and 3.
        step(4'b1010, 0, 0, 2'd2, 0);
        step('0, 0, 0, 2'd2, 0);
        chk("t2_cause1", 32'(bus.cause), 32'd1);
        chk("t2_pending8", bus.cfg_rdata, 32'h8);
        step('0, 1, 0, 2'd3, 0);
        chk("t2_reentry", 32'(bus.int_out), 32'd1);
        step('0, 0, 0, 2'd3, 0);
        chk("t2_cause3", 32'(bus.cause), 32'd3);
        step('0, 1, 0, 2'd3, 0);
        step(4'b1010, 0, 0, 2'd3, 0);
        step('0, 0, 0, 2'd3, 0);
        chk("t2_cause1_again", 32'(bus.cause), 32'd1);
        step('0, 1, 0, 2'd3, 0);
        step('0, 0, 0, 2'd3, 0);
        step('0, 1, 0, 2'd3, 0);
        idle(1);

        // gie=0 holds a request pending.
        step('0, 0, 1, 2'd1, 32'h0);
        step(4'b0001, 0, 0, 2'd2, 0);
        step('0, 0, 0, 2'd2, 0);
        chk("t3_no_int", 32'(bus.int_out), 32'd0);
        chk("t3_pending1", bus.cfg_rdata, 32'h1);
        step('0, 0, 1, 2'd1, 32'h1);
        chk("t3_int_after_gie", 32'(bus.int_out), 32'd1);
        step('0, 0, 0, 2'd3, 0);
        chk("t3_cause0", 32'(bus.cause), 32'd0);

        // Edge during eret.
        step(4'b0100, 1, 0, 2'd3, 0);
        chk("t4_int", 32'(bus.int_out), 32'd1);
        step('0, 0, 0, 2'd3, 0);
        chk("t4_cause2", 32'(bus.cause), 32'd2);
        step('0, 1, 0, 2'd3, 0);

        // Set beats W1C.
        step('0, 0, 1, 2'd1, 32'h0);
        step(4'b0010, 0, 1, 2'd2, 32'h2);
        chk("t5_set_wins", bus.cfg_rdata, 32'h2);
        step('0, 0, 1, 2'd2, 32'hF);
        step('0, 0, 1, 2'd1, 32'h1);

        // Reset mid-service.
        step(4'b1000, 0, 0, 2'd3, 0);
        step('0, 0, 0, 2'd3, 0);
        chk("t6_in_service", 32'(bus.in_service), 32'd1);
        do_reset();

        // Randomized traffic against the model.
        step('0, 0, 1, 2'd0, 32'hF);
        step('0, 0, 1, 2'd1, 32'h1);
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r_irq;
            logic         r_eret, r_we;
            logic [1:0]   r_addr;
            logic [31:0]  r_wd;
            r_irq  = N'($urandom) & N'($urandom) & N'($urandom);
            r_eret = ($urandom_range(0, 3) == 0);
            r_we   = ($urandom_range(0, 9) == 0);
            r_addr = 2'($urandom);
            r_wd   = $urandom;
            if (r_we && r_addr == 2'd1 && $urandom_range(0, 2) != 0) r_wd[0] = 1'b1;
            step(r_irq, r_eret, r_we, r_addr, r_wd);
            if (c == 1500) begin
                do_reset();
                step('0, 0, 1, 2'd0, 32'hF);
                step('0, 0, 1, 2'd1, 32'h1);
            end
        end
        idle(2);

        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d queued expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
